// File: rtl/pads_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// pads_rst_seq_pkg
// Shared definitions for the pad-ring reset sequencer. The pad-ring top and its
// testbench both use these, so state codes stay consistent everywhere.
//   STATE_W  : width of the sequencer state / debug state port
//   state_e  : sequencer state encodings (codes 5..7 are illegal)
//   max3()   : helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package pads_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_HOLD    = 3'd0,
    S_CLKWAIT = 3'd1,
    S_CORERST = 3'd2,
    S_OEWAIT  = 3'd3,
    S_RUN     = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pads_rst_seq_rst_sync.sv
// -----------------------------------------------------------------------------
// pads_rst_seq_rst_sync
// Reset synchroniser: asynchronous clear, synchronous release. The output goes
// high after STAGES rising edges of clk_i with rstn_i held high, and drops
// immediately (no clock needed) whenever rstn_i goes low.
// Ports:
//   clk_i        in  1  clock
//   rstn_i       in  1  raw asynchronous active-low reset
//   rst_sync_n_o out 1  synchronised active-low reset
// -----------------------------------------------------------------------------
module pads_rst_seq_rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic rst_sync_n_o
);

  logic [STAGES-1:0] sync_q;

  // A constant 1 is shifted in; only the release edge is synchronised.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/pads_rst_seq.sv
// -----------------------------------------------------------------------------
// pads_rst_seq
// Power-up / reset sequencer sitting directly behind the pad ring.
//   HOLD -> CLKWAIT (clock stabilisation) -> CORERST (core held in reset)
//   -> OEWAIT (core running, pads still tristated) -> RUN (pads may drive).
// A core soft-reset request in RUN re-enters CORERST, skipping the clock wait.
// Ports:
//   clk_i          in  1           core clock from clock pad
//   rstn_i         in  1           raw chip reset, async active-low
//   soft_rst_req_i in  1           core soft-reset request (only honoured in RUN)
//   pad_oe_req_i   in  N_OUT_PADS  per-pad output-enable request (1 = drive)
//   pad_oen_o      out N_OUT_PADS  pad OEN, active-low (1 = tristate)
//   core_rstn_o    out 1           core reset, async assert / sync deassert
//   ready_o        out 1           high while in RUN
//   state_o        out STATE_W     current state for debug/scan observation
// -----------------------------------------------------------------------------
module pads_rst_seq
  import pads_rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CLK_STABLE_CYC = 256,
  parameter int unsigned CORE_RST_CYC   = 16,
  parameter int unsigned OE_DELAY_CYC   = 8,
  parameter int unsigned N_OUT_PADS     = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  soft_rst_req_i,
  input  logic [N_OUT_PADS-1:0] pad_oe_req_i,
  output logic [N_OUT_PADS-1:0] pad_oen_o,
  output logic                  core_rstn_o,
  output logic                  ready_o,
  output logic [STATE_W-1:0]    state_o
);

  localparam int CNT_W = $clog2(max3(CLK_STABLE_CYC, CORE_RST_CYC, OE_DELAY_CYC)) + 1;

  // Each timed state is loaded with N-1 on entry and exits on the edge where
  // the count reads zero, giving exactly N cycles of residency.
  localparam logic [CNT_W-1:0] CLK_LOAD  = CNT_W'(CLK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LOAD = CNT_W'(CORE_RST_CYC - 1);
  localparam logic [CNT_W-1:0] OE_LOAD   = CNT_W'(OE_DELAY_CYC - 1);

  logic             rst_sync_n;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_rstn_q, core_rstn_d;
  logic             ready_q, ready_d;
  logic             oe_gate_q, oe_gate_d;

  (* dont_touch = "true" *)
  pads_rst_seq_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .rst_sync_n_o (rst_sync_n)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
    case (state_q)
      S_HOLD: begin
        if (rst_sync_n) begin
          state_d = S_CLKWAIT;
          cnt_d   = CLK_LOAD;
        end
      end
      S_CLKWAIT: begin
        if (cnt_q == '0) begin
          state_d = S_CORERST;
          cnt_d   = CORE_LOAD;
        end
      end
      S_CORERST: begin
        if (cnt_q == '0) begin
          state_d = S_OEWAIT;
          cnt_d   = OE_LOAD;
        end
      end
      S_OEWAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Soft reset skips the clock wait: the clock is already known good.
        if (soft_rst_req_i) begin
          state_d = S_CORERST;
          cnt_d   = CORE_LOAD;
        end
      end
      default: begin
        // Corrupted state (e.g. upset or scan): restart the whole sequence.
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are flops decoded from the next state, so they switch on the same
  // edge as the state and carry no combinational path from rstn_i.
  always_comb begin
    core_rstn_d = (state_d == S_OEWAIT) || (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    oe_gate_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      core_rstn_q <= 1'b0;
      ready_q     <= 1'b0;
      oe_gate_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_rstn_q <= core_rstn_d;
      ready_q     <= ready_d;
      oe_gate_q   <= oe_gate_d;
    end
  end

  // Single AND level per lane: requests reach the pads only while gated open.
  genvar gi;
  generate
    for (gi = 0; gi < int'(N_OUT_PADS); gi++) begin : g_oe_lane
      assign pad_oen_o[gi] = ~(pad_oe_req_i[gi] & oe_gate_q);
    end
  endgenerate

  assign core_rstn_o = core_rstn_q;
  assign ready_o     = ready_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pads_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pads_rst_seq
// Self-checking bench for pads_rst_seq. The reference model tracks only
// "edges since the (virtual) reset release" and maps that count onto the
// sequencer phase with threshold arithmetic; soft reset and illegal-state
// recovery are expressed as jumps of that count.
// -----------------------------------------------------------------------------
module tb_pads_rst_seq;
  import pads_rst_seq_pkg::*;

  localparam int SYNC = 2;
  localparam int CLKC = 4;
  localparam int CORE = 3;
  localparam int OED  = 2;
  localparam int N    = 4;

  // Edge counts (after release) at which each phase begins.
  localparam int T1 = SYNC + 1;   // CLKWAIT
  localparam int T2 = T1 + CLKC;  // CORERST
  localparam int T3 = T2 + CORE;  // OEWAIT
  localparam int T4 = T3 + OED;   // RUN

  logic               clk = 1'b0;
  logic               rstn_i = 1'b1;
  logic               soft_rst_req_i = 1'b0;
  logic [N-1:0]       pad_oe_req_i = 4'b1111;
  logic [N-1:0]       pad_oen_o;
  logic               core_rstn_o;
  logic               ready_o;
  logic [STATE_W-1:0] state_o;

  int  k = 0;
  bit  illegal_pending = 1'b0;
  int  edge_no = 0;
  int  n_pass = 0;
  int  n_checks = 0;

  always #5 clk = ~clk;

  pads_rst_seq #(
    .SYNC_STAGES    (SYNC),
    .CLK_STABLE_CYC (CLKC),
    .CORE_RST_CYC   (CORE),
    .OE_DELAY_CYC   (OED),
    .N_OUT_PADS     (N)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .soft_rst_req_i (soft_rst_req_i),
    .pad_oe_req_i   (pad_oe_req_i),
    .pad_oen_o      (pad_oen_o),
    .core_rstn_o    (core_rstn_o),
    .ready_o        (ready_o),
    .state_o        (state_o)
  );

  // ---------------- reference model ----------------
  function automatic int exp_state();
    if (k < T1) return int'(S_HOLD);
    if (k < T2) return int'(S_CLKWAIT);
    if (k < T3) return int'(S_CORERST);
    if (k < T4) return int'(S_OEWAIT);
    return int'(S_RUN);
  endfunction

  task automatic model_edge();
    if (!rstn_i) begin
      k = 0;
    end else if (illegal_pending) begin
      k = SYNC;  // lands in HOLD with the synchroniser already released
      illegal_pending = 1'b0;
    end else if (exp_state() == int'(S_RUN) && soft_rst_req_i) begin
      k = T2;
    end else if (k < T4) begin
      k++;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_no, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    int       st;
    logic     rdy;
    logic     crst;
    logic [N-1:0] oen;
    st   = exp_state();
    crst = (st == int'(S_OEWAIT)) || (st == int'(S_RUN));
    rdy  = (st == int'(S_RUN));
    oen  = ~(pad_oe_req_i & {N{rdy}});
    chk({tag, "/state"}, 32'(state_o), 32'(st));
    chk({tag, "/core_rstn"}, 32'(core_rstn_o), 32'(crst));
    chk({tag, "/ready"}, 32'(ready_o), 32'(rdy));
    chk({tag, "/pad_oen"}, 32'(pad_oen_o), 32'(oen));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic drop_rst(input string tag);
    rstn_i = 1'b0;
    k = 0;
    illegal_pending = 1'b0;
    #1;
    chk_all(tag);
  endtask

  task automatic release_at_negedge();
    @(negedge clk);
    rstn_i  = 1'b1;
    edge_no = 0;
  endtask

  // Power-up with the spec's absolute edge numbers as extra expectations.
  task automatic powerup_run(input string tag, input int n_edges);
    for (int i = 1; i <= n_edges; i++) begin
      tick(tag);
      chk({tag, "/core_at_edge"}, 32'(core_rstn_o), 32'(i >= 10));
      chk({tag, "/ready_at_edge"}, 32'(ready_o), 32'(i >= 12));
      if (i == 11) begin
        pad_oe_req_i = 4'b0101;
        #1;
        chk({tag, "/gate_closed"}, 32'(pad_oen_o), 32'(4'b1111));
        pad_oe_req_i = 4'b1111;
      end
    end
  endtask

  initial begin
    int r;

    // Reset state
    #2;
    drop_rst("reset");
    tick("reset_hold");
    tick("reset_hold");

    // 1/2: power-up and gating
    release_at_negedge();
    powerup_run("powerup", 14);
    pad_oe_req_i = 4'b0101;
    #1;
    chk("gate_run", 32'(pad_oen_o), 32'(4'b1010));
    chk_all("gate_run_model");

    // 3: single-cycle soft reset
    soft_rst_req_i = 1'b1;
    tick("soft_edge");
    soft_rst_req_i = 1'b0;
    chk("soft_state", 32'(state_o), 32'(S_CORERST));
    chk("soft_oen", 32'(pad_oen_o), 32'(4'b1111));
    for (int i = 0; i < 6; i++) tick("soft_seq");

    // 4: reset dropped between edges 8 and 9, then re-release
    pad_oe_req_i = 4'b1111;
    drop_rst("mid_pre");
    tick("mid_pre_hold");
    release_at_negedge();
    for (int i = 0; i < 8; i++) tick("mid_seq");
    drop_rst("mid_async");
    chk("mid_async_core", 32'(core_rstn_o), 32'd0);
    tick("mid_hold");
    release_at_negedge();
    powerup_run("rerelease", 13);

    // 6: illegal state recovery
    force dut.state_q = state_e'(3'd6);
    #1;
    chk("illegal_seen", 32'(state_o), 32'd6);
    release dut.state_q;
    illegal_pending = 1'b1;
    tick("illegal_edge");
    chk("illegal_to_hold", 32'(state_o), 32'(S_HOLD));
    for (int i = 0; i < 12; i++) tick("illegal_seq");

    // Sub-cycle glitch on rstn_i while running
    drop_rst("glitch");
    rstn_i = 1'b1;
    edge_no = 0;
    for (int i = 0; i < 13; i++) tick("glitch_seq");

    // 5: soft request held high from before release
    drop_rst("held_pre");
    soft_rst_req_i = 1'b1;
    tick("held_hold");
    release_at_negedge();
    for (int i = 0; i < 22; i++) tick("held_seq");
    soft_rst_req_i = 1'b0;
    for (int i = 0; i < 6; i++) tick("held_done");

    // Randomised traffic
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      pad_oe_req_i = N'($urandom);
      soft_rst_req_i = ($urandom_range(0, 7) == 0);
      #1;
      chk_all("rnd_req");
      if (r < 3) begin
        drop_rst("rnd_glitch");
        rstn_i = 1'b1;
        edge_no = 0;
      end else if (r < 5) begin
        drop_rst("rnd_drop");
        tick("rnd_drop_hold");
        rstn_i = 1'b1;
        edge_no = 0;
      end
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
